// File: rtl/mmu_iso_ctrl.sv
// Power-gating isolation controller for MMU match channels.
// Each channel clamps its outputs until power-good has settled.
module mmu_iso_ctrl #(
    parameter int NCH    = 2,
    parameter int DW     = 32,
    parameter int MW     = 16,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    pg_mmu,
    input  logic [NCH-1:0]    pwr_off_req,
    input  logic [NCH-1:0]    err_clr,
    input  logic [NCH*DW-1:0] mtch_data,
    input  logic [NCH-1:0]    mtch_rslt,
    input  logic [NCH*MW-1:0] mmc_mtch_rslt,
    output logic [NCH*DW-1:0] iso_mtch_data,
    output logic [NCH-1:0]    iso_mtch_rslt,
    output logic [NCH*MW-1:0] iso_mmc_mtch_rslt,
    output logic [NCH-1:0]    iso_active,
    output logic [NCH-1:0]    pwr_off_ack,
    output logic [NCH-1:0]    pg_err
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_ISO    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_ch
            state_t          state_q;
            state_t          state_d;
            logic [CW-1:0]   cnt_q;
            logic [CW-1:0]   cnt_d;
            logic            err_q;
            logic            err_d;
            logic            en;

            // Channel state, settle counter and sticky error register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_ISO;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    err_q   <= err_d;
                end
            end

            // Next-state, settle counting and error set/clear decisions.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                err_d   = err_q;
                unique case (state_q)
                    ST_ISO: begin
                        cnt_d = '0;
                        if (pg_mmu[i] && !pwr_off_req[i]) begin
                            state_d = ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (!pg_mmu[i] || pwr_off_req[i]) begin
                            state_d = ST_ISO;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        cnt_d = '0;
                        if (!pg_mmu[i] || pwr_off_req[i]) begin
                            state_d = ST_ISO;
                        end
                    end
                    default: begin
                        state_d = ST_ISO;
                        cnt_d   = '0;
                    end
                endcase
                // A lost supply outranks a clear landing on the same edge;
                // an orderly power-off request masks the loss.
                if (err_clr[i]) begin
                    err_d = 1'b0;
                end
                if (state_q == ST_RUN && !pg_mmu[i] && !pwr_off_req[i]) begin
                    err_d = 1'b1;
                end
            end

            // Raw power-good gates the clamp so a supply drop isolates at once.
            assign en = (state_q == ST_RUN) & pg_mmu[i];

            assign iso_mtch_data[i*DW +: DW] =
                mtch_data[i*DW +: DW] & {DW{en}};
            assign iso_mmc_mtch_rslt[i*MW +: MW] =
                mmc_mtch_rslt[i*MW +: MW] & {MW{en}};
            assign iso_mtch_rslt[i] = mtch_rslt[i] & en;
            assign iso_active[i]    = ~en;
            assign pwr_off_ack[i]   = (state_q == ST_ISO);
            assign pg_err[i]        = err_q;
        end
    endgenerate

endmodule

// File: tb/tb_mmu_iso_ctrl.sv
// Directed bench for mmu_iso_ctrl with NCH=2, SETTLE=4.
module tb_mmu_iso_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pg_mmu;
    logic [1:0]  pwr_off_req;
    logic [1:0]  err_clr;
    logic [63:0] mtch_data;
    logic [1:0]  mtch_rslt;
    logic [31:0] mmc_mtch_rslt;
    logic [63:0] iso_mtch_data;
    logic [1:0]  iso_mtch_rslt;
    logic [31:0] iso_mmc_mtch_rslt;
    logic [1:0]  iso_active;
    logic [1:0]  pwr_off_ack;
    logic [1:0]  pg_err;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] D_BOTH = 64'h12345678_DEADBEEF;
    localparam logic [63:0] D_CH0  = 64'h00000000_DEADBEEF;
    localparam logic [63:0] D_CH1  = 64'h12345678_00000000;

    mmu_iso_ctrl #(.NCH(2), .DW(32), .MW(16), .SETTLE(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .pg_mmu            (pg_mmu),
        .pwr_off_req       (pwr_off_req),
        .err_clr           (err_clr),
        .mtch_data         (mtch_data),
        .mtch_rslt         (mtch_rslt),
        .mmc_mtch_rslt     (mmc_mtch_rslt),
        .iso_mtch_data     (iso_mtch_data),
        .iso_mtch_rslt     (iso_mtch_rslt),
        .iso_mmc_mtch_rslt (iso_mmc_mtch_rslt),
        .iso_active        (iso_active),
        .pwr_off_ack       (pwr_off_ack),
        .pg_err            (pg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b1;
        pg_mmu        = 2'b00;
        pwr_off_req   = 2'b00;
        err_clr       = 2'b00;
        mtch_data     = D_BOTH;
        mtch_rslt     = 2'b11;
        mmc_mtch_rslt = 32'hBEEF_CAFE;
        tick();
        tick();
        chk("rst_active", 64'(iso_active), 64'h3);
        chk("rst_ack", 64'(pwr_off_ack), 64'h3);
        chk("rst_err", 64'(pg_err), 64'h0);
        chk("rst_data", iso_mtch_data, 64'h0);
        rst = 1'b0;

        // ch0 power-up: first sampling edge is e1, pass-through after e5
        pg_mmu = 2'b01;
        tick();
        chk("settle_ack", 64'(pwr_off_ack), 64'h2);
        chk("settle_d1", iso_mtch_data, 64'h0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("settle_dk", iso_mtch_data, 64'h0);
        end
        tick();
        chk("run0_data", iso_mtch_data, D_CH0);
        chk("run0_rslt", 64'(iso_mtch_rslt), 64'h1);
        chk("run0_mmc", 64'(iso_mmc_mtch_rslt), 64'h0000_CAFE);
        chk("run0_active", 64'(iso_active), 64'h2);
        chk("run0_ack", 64'(pwr_off_ack), 64'h2);

        // ch1 power-up, then mid-cycle supply drop
        pg_mmu = 2'b11;
        for (int k = 0; k < 5; k++) tick();
        chk("run01_data", iso_mtch_data, D_BOTH);
        chk("run01_mmc", 64'(iso_mmc_mtch_rslt), 64'hBEEF_CAFE);
        #3;
        pg_mmu = 2'b01;
        #1;
        chk("drop1_rslt", 64'(iso_mtch_rslt), 64'h1);
        chk("drop1_active", 64'(iso_active), 64'h2);
        chk("drop1_data", iso_mtch_data, D_CH0);
        chk("drop1_err_pre", 64'(pg_err), 64'h0);
        tick();
        chk("drop1_err", 64'(pg_err), 64'h2);
        chk("drop1_ack", 64'(pwr_off_ack), 64'h2);
        err_clr = 2'b10;
        tick();
        err_clr = 2'b00;
        chk("clr1_err", 64'(pg_err), 64'h0);

        // set and clear on the same edge: set wins
        pg_mmu = 2'b11;
        for (int k = 0; k < 5; k++) tick();
        chk("rerun1_data", iso_mtch_data, D_BOTH);
        pg_mmu  = 2'b01;
        err_clr = 2'b10;
        tick();
        err_clr = 2'b00;
        chk("setclr_err", 64'(pg_err), 64'h2);
        err_clr = 2'b10;
        tick();
        err_clr = 2'b00;
        chk("setclr_clear", 64'(pg_err), 64'h0);

        // orderly power-off of ch0
        pwr_off_req = 2'b01;
        tick();
        chk("off0_active", 64'(iso_active), 64'h3);
        chk("off0_ack", 64'(pwr_off_ack), 64'h3);
        chk("off0_data", iso_mtch_data, 64'h0);
        chk("off0_err", 64'(pg_err), 64'h0);

        // settle glitch: 3 high edges, 1 low, then a full restart
        pwr_off_req = 2'b00;
        for (int k = 0; k < 3; k++) tick();
        chk("glitch_pre_ack", 64'(pwr_off_ack), 64'h2);
        pg_mmu = 2'b00;
        tick();
        chk("glitch_ack", 64'(pwr_off_ack), 64'h3);
        pg_mmu = 2'b01;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("restart_hold", iso_mtch_data, 64'h0);
        end
        tick();
        chk("restart_run", iso_mtch_data, D_CH0);

        // ch1 in RUN: supply loss and off request on the same edge
        pg_mmu = 2'b11;
        for (int k = 0; k < 5; k++) tick();
        chk("both_run", iso_mtch_data, D_BOTH);
        pg_mmu      = 2'b01;
        pwr_off_req = 2'b10;
        tick();
        chk("both_ev_err", 64'(pg_err), 64'h0);
        chk("both_ev_ack", 64'(pwr_off_ack), 64'h2);
        pwr_off_req = 2'b00;

        // ch0 supply loss leaves pg_err[0] set before reset
        pg_mmu = 2'b10;
        tick();
        chk("drop0_err", 64'(pg_err), 64'h1);
        pg_mmu = 2'b11;
        for (int k = 0; k < 5; k++) tick();
        chk("pre_rst_data", iso_mtch_data, D_BOTH);
        chk("pre_rst_err", 64'(pg_err), 64'h1);

        // one-cycle reset with pg held high throughout
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_data", iso_mtch_data, 64'h0);
        chk("mrst_rslt", 64'(iso_mtch_rslt), 64'h0);
        chk("mrst_mmc", 64'(iso_mmc_mtch_rslt), 64'h0);
        chk("mrst_active", 64'(iso_active), 64'h3);
        chk("mrst_ack", 64'(pwr_off_ack), 64'h3);
        chk("mrst_err", 64'(pg_err), 64'h0);
        tick();
        chk("post_rst_ack", 64'(pwr_off_ack), 64'h0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("post_rst_hold", iso_mtch_data, 64'h0);
        end
        tick();
        chk("post_rst_run", iso_mtch_data, D_BOTH);
        chk("post_rst_act", 64'(iso_active), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
